// File: rtl/ula_pkg.sv
// ula_pkg: shared op codes, widths and arbiter state encoding for the ula and its request arbiter
package ula_pkg;
  localparam int OP_W = 5;
  localparam int DATA_W = 16;
  localparam int RES_W = 32;
  typedef enum logic [3:0] {
    OP_UNUSED = 4'd0,
    OP_ADD    = 4'd1,
    OP_SUB    = 4'd2,
    OP_MUL    = 4'd3,
    OP_DIV    = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_XOR    = 4'd7,
    OP_REV    = 4'd8
  } ula_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} arb_state_e;
  function automatic logic [OP_W-1:0] op5(input ula_op_e o);
    return {1'b0, o};
  endfunction
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op != '0 && op <= op5(OP_REV);
  endfunction
endpackage

// File: rtl/ula_rr_pick.sv
// ula_rr_pick: combinational round-robin picker, first valid index at/after ptr with wrap
module ula_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  function automatic int wrap(input int p, input int k);
    return (p + k) % N;
  endfunction
  // Scan from farthest to nearest so the closest valid index at/after ptr wins.
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[wrap(int'(ptr), k)]) begin
        grant = N'(1) << wrap(int'(ptr), k);
        idx = IW'(wrap(int'(ptr), k));
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ula_req_arbiter.sv
// ula_req_arbiter: round-robin sharing of one ula among N_REQ requesters; ULA_ARB_DIV0_CHK_EN rejects DIV by zero
module ula_req_arbiter
  import ula_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int WAIT_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][OP_W-1:0]    req_op,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_b,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [RES_W-1:0]              rsp_result,
  output logic                          rsp_carry,
  output logic                          rsp_err,
  output logic [OP_W-1:0]               alu_op,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  input  logic                          alu_valid,
  input  logic [RES_W-1:0]              alu_result,
  input  logic                          alu_carry
);
  localparam int CW = $clog2(WAIT_MAX);
  arb_state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d, rsp_err_q, rsp_err_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0] win;
  logic any, bad;
  ula_rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
    .valid(req_valid),
    .ptr  (ptr_q),
    .grant(grant),
    .idx  (win),
    .any  (any)
  );
`ifdef ULA_ARB_DIV0_CHK_EN
  assign bad = !op_legal(req_op[win]) || (req_op[win] == op5(OP_DIV) && req_b[win] == '0);
`else
  assign bad = !op_legal(req_op[win]);
`endif
  // Grant only from IDLE; held low during reset so no request is taken while the FSM is cleared.
  assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err = rsp_err_q;
  assign alu_op = alu_op_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  // Next-state: accept/reject in IDLE, issue once, wait for ula or timeout, hold response until taken.
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    alu_op_d = alu_op_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: if (any) begin
        ptr_d = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
        rsp_id_d = win;
        state_d = bad ? ST_RESP : ST_ISSUE;
        rsp_valid_d = bad;
        rsp_err_d = bad;
        rsp_result_d = '0;
        rsp_carry_d = 1'b0;
        alu_op_d = bad ? op5(OP_UNUSED) : req_op[win];
        alu_a_d = bad ? alu_a_q : req_a[win];
        alu_b_d = bad ? alu_b_q : req_b[win];
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d = '0;
      end
      ST_WAIT: if (alu_valid || cnt_q == CW'(WAIT_MAX - 1)) begin
        state_d = ST_RESP;
        alu_op_d = op5(OP_UNUSED);
        rsp_valid_d = 1'b1;
        rsp_err_d = !alu_valid;
        rsp_result_d = alu_valid ? alu_result : '0;
        rsp_carry_d = alu_valid & alu_carry;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: if (rsp_ready) begin
        state_d = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end
  // State and registered outputs; reset drops any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      alu_op_q <= op5(OP_UNUSED);
      alu_a_q <= '0;
      alu_b_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_result_q <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      alu_op_q <= alu_op_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_ula_req_arbiter.sv
// tb_ula_req_arbiter: directed checks of grant order, latency, errors, backpressure, reset and timeout
module tb_ula_req_arbiter;
  localparam int N = 4;
  localparam int IW = 2;
  localparam int WM = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0][4:0] req_op = '0;
  logic [N-1:0][15:0] req_a = '0;
  logic [N-1:0][15:0] req_b = '0;
  logic rsp_valid, rsp_carry, rsp_err;
  logic rsp_ready = 1'b1;
  logic [IW-1:0] rsp_id;
  logic [31:0] rsp_result;
  logic [4:0] alu_op;
  logic [15:0] alu_a, alu_b;
  logic alu_valid = 1'b0;
  logic alu_carry = 1'b0;
  logic [31:0] alu_result = '0;
  logic stall = 1'b0;
  int vec = 0;
  int errs = 0;
  always #5 clk = ~clk;
  ula_req_arbiter #(.N_REQ(N), .ID_W(IW), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_valid(alu_valid), .alu_result(alu_result), .alu_carry(alu_carry)
  );
  function automatic logic [32:0] ula_model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    case (op)
      5'd1: begin s = 17'(a) + 17'(b); return {s[16], 16'h0, s[15:0]}; end
      5'd2: begin s = 17'(a) - 17'(b); return {s[16], 16'h0, s[15:0]}; end
      5'd3: return {1'b0, 32'(a) * 32'(b)};
      5'd4: return {1'b0, (b == 16'h0) ? 32'hFFFF_FFFF : 32'(a / b)};
      5'd5: return {17'h0, a & b};
      5'd6: return {17'h0, a | b};
      5'd7: return {17'h0, a ^ b};
      default: return '0;
    endcase
  endfunction
  // Stand-in ula: registers the op once, stall suppresses valid to force a timeout.
  always @(posedge clk) begin
    alu_valid <= !stall && alu_op != 5'd0;
    {alu_carry, alu_result} <= ula_model(alu_op, alu_a, alu_b);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op[i] = op;
    req_a[i] = a;
    req_b[i] = b;
  endtask
  task automatic wait_grant(input string tag, input logic [N-1:0] exp);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(req_ready), 32'(exp));
  endtask
  task automatic wait_rsp(input string tag, input int lat, input logic [N-1:0] drop);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) req_valid = req_valid & ~drop;
    end
    chk(tag, 32'(n), 32'(lat));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    logic [1:0] ids [5];
    logic [31:0] res [5];
    ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    res = '{32'h5, 32'hF, 32'hF00, 32'h1234, 32'h5};
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'h0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst alu_op", 32'(alu_op), 32'h0);
    chk("rst alu_a", 32'(alu_a), 32'h0);
    chk("rst alu_b", 32'(alu_b), 32'h0);
    chk("rst rsp_result", rsp_result, 32'h0);
    chk("rst rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b0;
    set_req(0, 5'd1, 16'h0001, 16'hFFFF);
    req_valid = 4'b0001;
    wait_grant("t1 grant", 4'b0001);
    wait_rsp("t1 latency", 3, 4'b0001);
    chk("t1 result", rsp_result, 32'h0);
    chk("t1 carry", 32'(rsp_carry), 32'h1);
    chk("t1 id", 32'(rsp_id), 32'h0);
    chk("t1 err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    chk("t1 rsp drop", 32'(rsp_valid), 32'h0);
    do_reset();
    set_req(0, 5'd1, 16'h0002, 16'h0003);
    set_req(1, 5'd3, 16'h0003, 16'h0005);
    set_req(2, 5'd7, 16'h00F0, 16'h0FF0);
    set_req(3, 5'd6, 16'h1200, 16'h0034);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant("t2 grant", 4'b0001 << ids[i]);
      wait_rsp("t2 latency", 3, 4'b0000);
      chk("t2 id", 32'(rsp_id), 32'(ids[i]));
      chk("t2 result", rsp_result, res[i]);
    end
    req_valid = 4'b0000;
    set_req(2, 5'h0A, 16'h0007, 16'h0007);
    req_valid = 4'b0100;
    wait_grant("t3 grant", 4'b0100);
    chk("t3 alu_op idle", 32'(alu_op), 32'h0);
    wait_rsp("t3 latency", 1, 4'b0100);
    chk("t3 err", 32'(rsp_err), 32'h1);
    chk("t3 result", rsp_result, 32'h0);
    chk("t3 carry", 32'(rsp_carry), 32'h0);
    chk("t3 id", 32'(rsp_id), 32'h2);
    chk("t3 alu_op resp", 32'(alu_op), 32'h0);
    @(negedge clk);
    chk("t3 rsp drop", 32'(rsp_valid), 32'h0);
    chk("t3 alu_op after", 32'(alu_op), 32'h0);
    rsp_ready = 1'b0;
    set_req(1, 5'd1, 16'h0010, 16'h0020);
    req_valid = 4'b0010;
    wait_grant("t4 grant", 4'b0010);
    wait_rsp("t4 latency", 3, 4'b0010);
    set_req(0, 5'd1, 16'h0001, 16'h0001);
    set_req(3, 5'd1, 16'h0001, 16'h0001);
    req_valid = 4'b1001;
    repeat (5) begin
      @(negedge clk);
      chk("t4 hold valid", 32'(rsp_valid), 32'h1);
      chk("t4 hold result", rsp_result, 32'h30);
      chk("t4 hold id", 32'(rsp_id), 32'h1);
      chk("t4 no grant", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4 release", 32'(rsp_valid), 32'h0);
    chk("t4 next grant", 32'(req_ready), 32'h8);
    req_valid = 4'b0000;
    set_req(1, 5'd3, 16'h0003, 16'h0005);
    req_valid = 4'b0010;
    wait_grant("t5 grant", 4'b0010);
    @(negedge clk);
    chk("t5 issue op", 32'(alu_op), 32'h3);
    @(negedge clk);
    chk("t5 wait op", 32'(alu_op), 32'h3);
    rst = 1'b1;
    #1;
    chk("t5 rst alu_op", 32'(alu_op), 32'h0);
    chk("t5 rst alu_a", 32'(alu_a), 32'h0);
    chk("t5 rst req_ready", 32'(req_ready), 32'h0);
    chk("t5 rst rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_grant("t5 regrant", 4'b0010);
    wait_rsp("t5 latency", 3, 4'b0010);
    chk("t5 result", rsp_result, 32'hF);
    chk("t5 id", 32'(rsp_id), 32'h1);
    chk("t5 err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    stall = 1'b1;
    set_req(0, 5'd1, 16'h0001, 16'h0002);
    req_valid = 4'b0001;
    wait_grant("t6 grant wrap", 4'b0001);
    wait_rsp("t6 timeout latency", WM + 2, 4'b0001);
    chk("t6 err", 32'(rsp_err), 32'h1);
    chk("t6 result", rsp_result, 32'h0);
    chk("t6 carry", 32'(rsp_carry), 32'h0);
    chk("t6 id", 32'(rsp_id), 32'h0);
    stall = 1'b0;
    @(negedge clk);
    set_req(3, 5'd4, 16'h0010, 16'h0000);
    req_valid = 4'b1000;
    wait_grant("t7 grant", 4'b1000);
`ifdef ULA_ARB_DIV0_CHK_EN
    wait_rsp("t7 div0 latency", 1, 4'b1000);
    chk("t7 div0 err", 32'(rsp_err), 32'h1);
    chk("t7 div0 result", rsp_result, 32'h0);
    chk("t7 div0 alu_op", 32'(alu_op), 32'h0);
`else
    wait_rsp("t7 div0 latency", 3, 4'b1000);
    chk("t7 div0 err", 32'(rsp_err), 32'h0);
    chk("t7 div0 result", rsp_result, 32'hFFFF_FFFF);
`endif
    chk("t7 id", 32'(rsp_id), 32'h3);
    @(negedge clk);
    set_req(3, 5'd4, 16'h0010, 16'h0002);
    req_valid = 4'b1000;
    wait_grant("t8 grant", 4'b1000);
    wait_rsp("t8 latency", 3, 4'b1000);
    chk("t8 result", rsp_result, 32'h8);
    chk("t8 err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
